// File: rtl/exec_seq_ctrl_if.sv
// Handshake/strobe bundle between exec_seq_ctrl (master) and the surrounding core (slave).
interface exec_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             fetch_req;
    logic             fetch_ack;
    logic [31:0]      fetch_data;
    logic [31:0]      inst_q;
    logic             dec_bubble;
    logic             dec_ren;
    logic             dec_wen;
    logic             dec_reg_we;
    logic             dec_csr_we;
    logic             dec_multi;
    logic             dec_ebreak;
    logic             alu_start;
    logic             alu_done;
    logic             lsu_req;
    logic             lsu_we;
    logic             lsu_ack;
    logic             rf_we;
    logic             csr_we;
    logic             pc_we;
    logic             halt;
    logic             err;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_o;

    modport master (
        output fetch_req, inst_q, dec_bubble, alu_start, lsu_req, lsu_we,
               rf_we, csr_we, pc_we, halt, err, retired, state_o,
        input  fetch_ack, fetch_data, dec_ren, dec_wen, dec_reg_we, dec_csr_we,
               dec_multi, dec_ebreak, alu_done, lsu_ack
    );

    modport slave (
        input  fetch_req, inst_q, dec_bubble, alu_start, lsu_req, lsu_we,
               rf_we, csr_we, pc_we, halt, err, retired, state_o,
        output fetch_ack, fetch_data, dec_ren, dec_wen, dec_reg_we, dec_csr_we,
               dec_multi, dec_ebreak, alu_done, lsu_ack
    );
endinterface

// File: rtl/exec_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the NPC core.
// Optional bus-wait timeout (-> sticky ERR) enabled by YSYX_23060059_BUS_TIMEOUT_EN.
module exec_seq_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    exec_seq_ctrl_if.master bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DECODE = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] MEM    = 3'd4;
    localparam logic [2:0] WB     = 3'd5;
    localparam logic [2:0] HALT   = 3'd6;
    localparam logic [2:0] ERR    = 3'd7;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [31:0]      inst_q;
    logic [CNT_W-1:0] retired;
    logic             alu_start;
    logic             mem_op;

    assign mem_op = bus.dec_ren | bus.dec_wen;

`ifdef YSYX_23060059_BUS_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [TW-1:0] wait_cnt;
    logic          wait_expired;

    // Counter holds the number of earlier waiting cycles; this cycle is the TIMEOUT-th.
    assign wait_expired = (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == FETCH || state == MEM) begin
            wait_cnt <= wait_cnt + TW'(1);
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH: begin
                if (bus.fetch_ack) state_nxt = DECODE;
`ifdef YSYX_23060059_BUS_TIMEOUT_EN
                else if (wait_expired) state_nxt = ERR;
`endif
            end
            DECODE: begin
                if (bus.dec_ebreak)     state_nxt = HALT;
                else if (bus.dec_multi) state_nxt = EXEC;
                else if (mem_op)        state_nxt = MEM;
                else                    state_nxt = WB;
            end
            EXEC: begin
                if (bus.alu_done) state_nxt = mem_op ? MEM : WB;
            end
            MEM: begin
                if (bus.lsu_ack) state_nxt = WB;
`ifdef YSYX_23060059_BUS_TIMEOUT_EN
                else if (wait_expired) state_nxt = ERR;
`endif
            end
            WB:     state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            ERR:    state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            inst_q    <= '0;
            retired   <= '0;
            alu_start <= 1'b0;
        end else begin
            state     <= state_nxt;
            alu_start <= (state == DECODE) && (state_nxt == EXEC);
            if (state == FETCH && bus.fetch_ack) inst_q <= bus.fetch_data;
            if (state == WB) retired <= retired + CNT_W'(1);
        end
    end

    // Strobes decode straight from state so an async reset clears them in the same cycle.
    assign bus.fetch_req  = (state == FETCH);
    assign bus.dec_bubble = !(state == DECODE || state == EXEC || state == MEM || state == WB);
    assign bus.lsu_req    = (state == MEM);
    assign bus.lsu_we     = (state == MEM) & bus.dec_wen;
    assign bus.rf_we      = (state == WB) & bus.dec_reg_we;
    assign bus.csr_we     = (state == WB) & bus.dec_csr_we;
    assign bus.pc_we      = (state == WB);
    assign bus.halt       = (state == HALT);
`ifdef YSYX_23060059_BUS_TIMEOUT_EN
    assign bus.err        = (state == ERR);
`else
    assign bus.err        = 1'b0;
`endif
    assign bus.alu_start  = alu_start;
    assign bus.inst_q     = inst_q;
    assign bus.retired    = retired;
    assign bus.state_o    = state;
endmodule

// File: tb/tb_exec_seq_ctrl.sv
// Directed self-checking bench for exec_seq_ctrl (timeout scenario under YSYX_23060059_BUS_TIMEOUT_EN).
`timescale 1ns/1ps
module tb_exec_seq_ctrl;
`ifdef YSYX_23060059_BUS_TIMEOUT_EN
    localparam int TOUT = 4;
`else
    localparam int TOUT = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;

    exec_seq_ctrl_if #(.CNT_W(32)) bus ();

    exec_seq_ctrl #(.CNT_W(32), .TIMEOUT(TOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fetch_ack  = 1'b0;
        bus.fetch_data = '0;
        bus.alu_done   = 1'b0;
        bus.lsu_ack    = 1'b0;
        bus.dec_ren    = 1'b0;
        bus.dec_wen    = 1'b0;
        bus.dec_reg_we = 1'b0;
        bus.dec_csr_we = 1'b0;
        bus.dec_multi  = 1'b0;
        bus.dec_ebreak = 1'b0;
    endtask

    task automatic set_dec(input logic ren, input logic wen, input logic reg_we,
                           input logic csr_we, input logic multi, input logic ebreak);
        bus.dec_ren    = ren;
        bus.dec_wen    = wen;
        bus.dec_reg_we = reg_we;
        bus.dec_csr_we = csr_we;
        bus.dec_multi  = multi;
        bus.dec_ebreak = ebreak;
    endtask

    // Called in FETCH; returns one cycle later (in DECODE) with fetch_ack dropped.
    task automatic do_fetch(input logic [31:0] data);
        bus.fetch_ack  = 1'b1;
        bus.fetch_data = data;
        tick();
        bus.fetch_ack  = 1'b0;
        bus.fetch_data = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.state_o !== 3'd0) $display("FAIL reset_state got=%0d exp=0", bus.state_o); else passed++;
        checks++; if (bus.inst_q !== 32'h0) $display("FAIL reset_inst_q got=%h exp=0", bus.inst_q); else passed++;
        checks++; if (bus.retired !== 32'd0) $display("FAIL reset_retired got=%0d exp=0", bus.retired); else passed++;
        checks++; if (bus.halt !== 1'b0 || bus.err !== 1'b0) $display("FAIL reset_flags got halt=%b err=%b exp=0/0", bus.halt, bus.err); else passed++;
        checks++; if (bus.dec_bubble !== 1'b1) $display("FAIL reset_bubble got=%b exp=1", bus.dec_bubble); else passed++;
        checks++; if ({bus.fetch_req, bus.lsu_req, bus.alu_start, bus.rf_we, bus.csr_we, bus.pc_we} !== 6'b0)
            $display("FAIL reset_strobes got=%b exp=000000", {bus.fetch_req, bus.lsu_req, bus.alu_start, bus.rf_we, bus.csr_we, bus.pc_we}); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_addi();
        set_dec(0, 0, 1, 0, 0, 0);
        tick();
        checks++; if (bus.state_o !== 3'd1 || bus.fetch_req !== 1'b1) $display("FAIL addi_fetch got state=%0d req=%b exp=1/1", bus.state_o, bus.fetch_req); else passed++;
        do_fetch(32'h00100093);
        checks++; if (bus.state_o !== 3'd2 || bus.dec_bubble !== 1'b0) $display("FAIL addi_decode got state=%0d bubble=%b exp=2/0", bus.state_o, bus.dec_bubble); else passed++;
        checks++; if (bus.inst_q !== 32'h00100093) $display("FAIL addi_inst_q got=%h exp=00100093", bus.inst_q); else passed++;
        tick();
        checks++; if (bus.state_o !== 3'd5) $display("FAIL addi_wb_state got=%0d exp=5", bus.state_o); else passed++;
        checks++; if (bus.rf_we !== 1'b1 || bus.pc_we !== 1'b1 || bus.csr_we !== 1'b0) $display("FAIL addi_wb_strobes got rf=%b pc=%b csr=%b exp=1/1/0", bus.rf_we, bus.pc_we, bus.csr_we); else passed++;
        bus.lsu_ack  = 1'b1;
        bus.alu_done = 1'b1;
        tick();
        bus.lsu_ack  = 1'b0;
        bus.alu_done = 1'b0;
        checks++; if (bus.state_o !== 3'd1 || bus.rf_we !== 1'b0) $display("FAIL addi_refetch got state=%0d rf_we=%b exp=1/0", bus.state_o, bus.rf_we); else passed++;
        checks++; if (bus.retired !== 32'd1) $display("FAIL addi_retired got=%0d exp=1", bus.retired); else passed++;
    endtask

    task automatic test_store();
        set_dec(0, 1, 0, 0, 0, 0);
        do_fetch(32'h00112023);
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++; if (bus.state_o !== 3'd4 || bus.lsu_req !== 1'b1 || bus.lsu_we !== 1'b1)
                $display("FAIL store_mem%0d got state=%0d req=%b we=%b exp=4/1/1", i, bus.state_o, bus.lsu_req, bus.lsu_we); else passed++;
            if (i == 2) bus.lsu_ack = 1'b1;
            tick();
        end
        bus.lsu_ack = 1'b0;
        checks++; if (bus.state_o !== 3'd5 || bus.lsu_req !== 1'b0) $display("FAIL store_wb got state=%0d req=%b exp=5/0", bus.state_o, bus.lsu_req); else passed++;
        checks++; if (bus.rf_we !== 1'b0 || bus.pc_we !== 1'b1) $display("FAIL store_wb_strobes got rf=%b pc=%b exp=0/1", bus.rf_we, bus.pc_we); else passed++;
        tick();
        checks++; if (bus.state_o !== 3'd1 || bus.retired !== 32'd2) $display("FAIL store_retire got state=%0d ret=%0d exp=1/2", bus.state_o, bus.retired); else passed++;
    endtask

    task automatic test_load_and_both();
        set_dec(1, 0, 1, 0, 0, 0);
        do_fetch(32'h00002103);
        tick();
        checks++; if (bus.lsu_req !== 1'b1 || bus.lsu_we !== 1'b0) $display("FAIL load_mem got req=%b we=%b exp=1/0", bus.lsu_req, bus.lsu_we); else passed++;
        bus.lsu_ack = 1'b1;
        tick();
        bus.lsu_ack = 1'b0;
        checks++; if (bus.state_o !== 3'd5 || bus.rf_we !== 1'b1) $display("FAIL load_wb got state=%0d rf=%b exp=5/1", bus.state_o, bus.rf_we); else passed++;
        tick();
        set_dec(1, 1, 0, 0, 0, 0);
        do_fetch(32'h00112023);
        tick();
        checks++; if (bus.state_o !== 3'd4 || bus.lsu_we !== 1'b1) $display("FAIL both_is_store got state=%0d we=%b exp=4/1", bus.state_o, bus.lsu_we); else passed++;
        bus.lsu_ack = 1'b1;
        tick();
        bus.lsu_ack = 1'b0;
        tick();
        checks++; if (bus.state_o !== 3'd1 || bus.retired !== 32'd4) $display("FAIL both_retire got state=%0d ret=%0d exp=1/4", bus.state_o, bus.retired); else passed++;
    endtask

    task automatic test_mul();
        set_dec(0, 0, 1, 0, 1, 0);
        do_fetch(32'h022080b3);
        checks++; if (bus.alu_start !== 1'b0) $display("FAIL mul_start_decode got=%b exp=0", bus.alu_start); else passed++;
        tick();
        for (int c = 1; c <= 6; c++) begin
            checks++; if (bus.state_o !== 3'd3) $display("FAIL mul_exec%0d_state got=%0d exp=3", c, bus.state_o); else passed++;
            checks++; if (bus.alu_start !== ((c == 1) ? 1'b1 : 1'b0)) $display("FAIL mul_exec%0d_start got=%b exp=%b", c, bus.alu_start, (c == 1)); else passed++;
            if (c == 6) bus.alu_done = 1'b1;
            tick();
        end
        bus.alu_done = 1'b0;
        checks++; if (bus.state_o !== 3'd5 || bus.rf_we !== 1'b1 || bus.alu_start !== 1'b0)
            $display("FAIL mul_wb got state=%0d rf=%b start=%b exp=5/1/0", bus.state_o, bus.rf_we, bus.alu_start); else passed++;
        tick();
        checks++; if (bus.retired !== 32'd5) $display("FAIL mul_retired got=%0d exp=5", bus.retired); else passed++;
    endtask

    task automatic test_alu_fast();
        set_dec(0, 0, 0, 1, 1, 0);
        bus.alu_done = 1'b1;
        do_fetch(32'h02209133);
        checks++; if (bus.state_o !== 3'd2) $display("FAIL fast_decode got=%0d exp=2", bus.state_o); else passed++;
        tick();
        checks++; if (bus.state_o !== 3'd3 || bus.alu_start !== 1'b1) $display("FAIL fast_exec got state=%0d start=%b exp=3/1", bus.state_o, bus.alu_start); else passed++;
        tick();
        bus.alu_done = 1'b0;
        checks++; if (bus.state_o !== 3'd5 || bus.csr_we !== 1'b1 || bus.rf_we !== 1'b0)
            $display("FAIL fast_wb got state=%0d csr=%b rf=%b exp=5/1/0", bus.state_o, bus.csr_we, bus.rf_we); else passed++;
        tick();
        checks++; if (bus.state_o !== 3'd1 || bus.retired !== 32'd6) $display("FAIL fast_refetch got state=%0d ret=%0d exp=1/6", bus.state_o, bus.retired); else passed++;
    endtask

    task automatic test_ebreak();
        int bad;
        set_dec(0, 0, 1, 0, 1, 1);
        do_fetch(32'h00100073);
        tick();
        checks++; if (bus.state_o !== 3'd6 || bus.halt !== 1'b1) $display("FAIL ebreak_halt got state=%0d halt=%b exp=6/1", bus.state_o, bus.halt); else passed++;
        bus.fetch_ack = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (bus.halt !== 1'b1 || bus.fetch_req !== 1'b0 || bus.pc_we !== 1'b0 || bus.state_o !== 3'd6 || bus.alu_start !== 1'b0) bad++;
            tick();
        end
        bus.fetch_ack = 1'b0;
        checks++; if (bad !== 0) $display("FAIL ebreak_hold got bad_cycles=%0d exp=0", bad); else passed++;
        checks++; if (bus.retired !== 32'd6) $display("FAIL ebreak_retired got=%0d exp=6", bus.retired); else passed++;
    endtask

    task automatic test_reset_mid_mem();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.halt !== 1'b0 || bus.retired !== 32'd0) $display("FAIL rst_halt_clear got halt=%b ret=%0d exp=0/0", bus.halt, bus.retired); else passed++;
        tick();
        set_dec(1, 0, 1, 0, 0, 0);
        do_fetch(32'h00002103);
        tick();
        checks++; if (bus.state_o !== 3'd4 || bus.lsu_req !== 1'b1) $display("FAIL rst_pre_mem got state=%0d req=%b exp=4/1", bus.state_o, bus.lsu_req); else passed++;
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.state_o !== 3'd0) $display("FAIL rst_mid_state got=%0d exp=0", bus.state_o); else passed++;
        checks++; if (bus.lsu_req !== 1'b0 || bus.dec_bubble !== 1'b1 || bus.inst_q !== 32'h0)
            $display("FAIL rst_mid_outputs got req=%b bubble=%b inst=%h exp=0/1/0", bus.lsu_req, bus.dec_bubble, bus.inst_q); else passed++;
        #1 rst = 1'b0;
        set_dec(0, 0, 1, 0, 0, 0);
        tick();
        checks++; if (bus.state_o !== 3'd1 || bus.fetch_req !== 1'b1) $display("FAIL rst_refetch got state=%0d req=%b exp=1/1", bus.state_o, bus.fetch_req); else passed++;
        do_fetch(32'h00100093);
        checks++; if (bus.inst_q !== 32'h00100093) $display("FAIL rst_refetch_inst got=%h exp=00100093", bus.inst_q); else passed++;
        tick();
        tick();
        checks++; if (bus.state_o !== 3'd1 || bus.retired !== 32'd1) $display("FAIL rst_refetch_retire got state=%0d ret=%0d exp=1/1", bus.state_o, bus.retired); else passed++;
    endtask

`ifdef YSYX_23060059_BUS_TIMEOUT_EN
    task automatic test_timeout();
        set_dec(0, 1, 0, 0, 0, 0);
        do_fetch(32'h00112023);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.lsu_ack = 1'b1;
            tick();
        end
        bus.lsu_ack = 1'b0;
        checks++; if (bus.state_o !== 3'd5 || bus.err !== 1'b0) $display("FAIL to_ack_wins got state=%0d err=%b exp=5/0", bus.state_o, bus.err); else passed++;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.state_o !== 3'd1 || bus.err !== 1'b0) $display("FAIL to_wait%0d got state=%0d err=%b exp=1/0", i, bus.state_o, bus.err); else passed++;
            tick();
        end
        checks++; if (bus.state_o !== 3'd7 || bus.err !== 1'b1 || bus.fetch_req !== 1'b0)
            $display("FAIL to_err got state=%0d err=%b req=%b exp=7/1/0", bus.state_o, bus.err, bus.fetch_req); else passed++;
        bus.fetch_ack = 1'b1;
        repeat (10) tick();
        bus.fetch_ack = 1'b0;
        checks++; if (bus.err !== 1'b1 || bus.fetch_req !== 1'b0 || bus.lsu_req !== 1'b0)
            $display("FAIL to_sticky got err=%b req=%b lsu=%b exp=1/0/0", bus.err, bus.fetch_req, bus.lsu_req); else passed++;
    endtask
`else
    task automatic test_timeout();
        repeat (300) tick();
        checks++; if (bus.state_o !== 3'd1 || bus.err !== 1'b0 || bus.fetch_req !== 1'b1)
            $display("FAIL nto_wait got state=%0d err=%b req=%b exp=1/0/1", bus.state_o, bus.err, bus.fetch_req); else passed++;
        set_dec(0, 0, 1, 0, 0, 0);
        do_fetch(32'h00100093);
        checks++; if (bus.state_o !== 3'd2) $display("FAIL nto_late_ack got state=%0d exp=2", bus.state_o); else passed++;
    endtask
`endif

    initial begin
        test_reset();
        test_addi();
        test_store();
        test_load_and_both();
        test_mul();
        test_alu_fast();
        test_ebreak();
        test_reset_mid_mem();
        test_timeout();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
